// File: rtl/ram_sdp_be_pipe.sv
// Simple-dual-port RAM with per-lane write enables, optional output register,
// read-during-write forwarding and a post-reset zero sweep.
module ram_sdp_be_pipe #(
  parameter int ADDR_W         = 9,
  parameter int DATA_W         = 16,
  parameter int WEN_W          = 2,
  parameter int OUT_REG        = 1,
  parameter int BYPASS         = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [ADDR_W-1:0] WA,
  input  logic [DATA_W-1:0] WD,
  input  logic [WEN_W-1:0]  WEN,
  input  logic              WClk_En,
  input  logic [ADDR_W-1:0] RA,
  input  logic              RClk_En,
  output logic [DATA_W-1:0] RD,
  output logic              RValid,
  output logic              Busy
);

  localparam int LANE_W = DATA_W / WEN_W;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(DEPTH - 1);

  if (DATA_W % WEN_W != 0) begin : g_bad_lanes
    $error("DATA_W must be a multiple of WEN_W");
  end
  if (OUT_REG != 0 && OUT_REG != 1) begin : g_bad_out_reg
    $error("OUT_REG must be 0 or 1");
  end
  if (BYPASS != 0 && BYPASS != 1) begin : g_bad_bypass
    $error("BYPASS must be 0 or 1");
  end

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t            state_reg;
  logic [ADDR_W:0]   clr_cnt_reg;
  logic              busy_reg;
  logic              v1_reg;
  logic [DATA_W-1:0] d1_data;

  logic              clearing;
  logic              wr_go;
  logic              rd_go;
  logic [ADDR_W-1:0] mem_wa;

  // Rst gates the array port too, so nothing lands in the array while reset is held.
  assign clearing = (state_reg == ST_CLEAR) && !Rst;
  assign wr_go    = !busy_reg && !Rst && WClk_En && (|WEN);
  assign rd_go    = !busy_reg && RClk_En;
  assign mem_wa   = clearing ? clr_cnt_reg[ADDR_W-1:0] : WA;
  assign Busy     = busy_reg;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_reg   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      clr_cnt_reg <= '0;
      busy_reg    <= (CLEAR_ON_RESET != 0);
    end else begin
      case (state_reg)
        ST_CLEAR: begin
          clr_cnt_reg <= clr_cnt_reg + 1'b1;
          if (clr_cnt_reg == LAST_ADDR) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < WEN_W; gi++) begin : g_lane
    logic [LANE_W-1:0] mem [DEPTH];
    logic [LANE_W-1:0] q_reg;
    logic              lane_we;
    logic [LANE_W-1:0] lane_wd;
    logic              fwd;

    assign lane_we = clearing || (wr_go && WEN[gi]);
    assign lane_wd = clearing ? '0 : WD[gi*LANE_W +: LANE_W];
    assign fwd     = (BYPASS != 0) && wr_go && WEN[gi] && (WA == RA);

    always_ff @(posedge Clk) begin
      if (lane_we) begin
        mem[mem_wa] <= lane_wd;
      end
    end

    // Array read is old-data on a collision; forwarding substitutes the written lane.
    always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
        q_reg <= '0;
      end else if (rd_go) begin
        q_reg <= fwd ? WD[gi*LANE_W +: LANE_W] : mem[RA];
      end
    end

    assign d1_data[gi*LANE_W +: LANE_W] = q_reg;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      v1_reg <= 1'b0;
    end else begin
      v1_reg <= rd_go;
    end
  end

  if (OUT_REG == 1) begin : g_out_reg
    logic [DATA_W-1:0] d2_reg;
    logic              v2_reg;

    always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
        d2_reg <= '0;
        v2_reg <= 1'b0;
      end else begin
        v2_reg <= v1_reg;
        if (v1_reg) begin
          d2_reg <= d1_data;
        end
      end
    end

    assign RD     = d2_reg;
    assign RValid = v2_reg;
  end else begin : g_no_out_reg
    assign RD     = d1_data;
    assign RValid = v1_reg;
  end

endmodule

// File: doc/ram_sdp_be_pipe.md
Name: ram_sdp_be_pipe

Overview:
Parametrised single-clock simple-dual-port RAM. It is the successor to the fixed 512x16 block-RAM wrapper, generalised in depth, width and byte-lane count.
Adds the following, none of which the fixed wrapper has:
- an optional output register stage
- read-during-write forwarding
- a post-reset clear sequencer
- a read-valid strobe

Sits between datapath logic and inferred block RAM wherever a known-zero, lane-writable buffer is needed.

Parameters:
- ADDR_W, 9, address width; depth = 2^ADDR_W words
- DATA_W, 16, word width in bits
- WEN_W, 2, number of write-enable lanes; lane width L = DATA_W/WEN_W
- OUT_REG, 1, 1 = extra output register (read latency 2); 0 = latency 1
- BYPASS, 1, 1 = same-cycle same-address read returns the newly written lanes; 0 = returns old data
- CLEAR_ON_RESET, 1, 1 = zero the whole array after reset; 0 = no clear, Busy low after reset

Ports:
- Clk  in  1  single clock, rising edge
- Rst  in  1  asynchronous, active-high reset
- WA  in  ADDR_W  write address
- WD  in  DATA_W  write data
- WEN  in  WEN_W  per-lane write enable; lane i = WD[i*L +: L]
- WClk_En  in  1  write qualifier
- RA  in  ADDR_W  read address
- RClk_En  in  1  read request
- RD  out  DATA_W  read data
- RValid  out  1  one-cycle strobe marking new data on RD
- Busy  out  1  high while in reset or clearing; all requests ignored while high

Behaviour:
- Elaboration error if DATA_W % WEN_W != 0, OUT_REG not in {0,1}, or BYPASS not in {0,1}.
- Rst asserted, without waiting for a clock:
  - RD=0, RValid=0, all pipeline valids=0, clear counter=0.
  - Busy=1 if CLEAR_ON_RESET, else 0.
  - Array contents are not reset.
- Clear FSM, states CLEAR and IDLE:
  - Entered into CLEAR on reset when CLEAR_ON_RESET=1, else into IDLE.
  - In CLEAR, each rising edge writes 0 to address cnt, then cnt+1.
  - The edge that writes address 2^ADDR_W-1 moves the FSM to IDLE and drops Busy. Busy is therefore high for exactly 2^ADDR_W edges after Rst falls.
  - Rst asserted mid-clear aborts the sweep; it restarts from address 0 after release.
  - The counter is ADDR_W+1 bits so the terminal compare cannot alias.
- Write, IDLE only:
  - Taken at the edge when WClk_En=1 and WEN!=0.
  - Only lanes with WEN[i]=1 change; other lanes keep their value.
  - WClk_En=1 with WEN=0 is a no-op.
- Read, IDLE only:
  - Issued at the edge when RClk_En=1.
  - Stage-1 register captures the array word and sets v1.
  - OUT_REG=0: RD = stage 1, RValid = v1. Data appears one edge after issue.
  - OUT_REG=1: stage 2 loads stage-1 data only when v1=1, RValid = v2. Data appears two edges after issue.
  - RD holds its last value when no new data arrives. RValid is never asserted more than once per request.
- Back-to-back reads, one per cycle, sustain full throughput. There is no stall or backpressure.
- Read and write to the same address in the same cycle:
  - BYPASS=1: lanes enabled in WEN return WD; other lanes return the old data.
  - BYPASS=0: the whole old word is returned.
  - The array is written in either case.
- Write at cycle N, read of the same address at cycle N+1: always returns the new data, regardless of BYPASS.
- Requests presented while Busy=1 are dropped:
  - no array change;
  - no RValid;
  - no late completion after Busy falls.
- Reads already in the pipeline when Rst asserts are discarded. RValid goes to 0 immediately.

Test Plan:
- Clear sweep: defaults, pulse Rst, count edges.
  - Required: Busy high for exactly 512 edges after Rst falls.
  - Then read 0x000, 0x0FF, 0x1FF -> RD=0x0000 each, RValid 2 cycles after each issue.
- Lane write:
  - Write 0x1234, WEN=2'b11 to 0x010.
  - Then write 0xABCD, WEN=2'b01 to 0x010.
  - Read 0x010 -> 0x12CD.
  - Write with WEN=2'b00 -> word unchanged.
- Forwarding: 0x020 holds 0x1111; same cycle write 0xBEEF with WEN=2'b10 and read 0x020.
  - BYPASS=1 -> 0xBE11.
  - BYPASS=0 -> 0x1111.
  - Following read of 0x020 -> 0xBE11 in both builds.
- Latency and throughput: OUT_REG=0 and OUT_REG=1 builds, 8 consecutive reads of 0x000..0x007 preloaded with index values.
  - RD sequence 0..7 with RValid high 8 consecutive cycles.
  - Starts 1 cycle after first issue (OUT_REG=0) or 2 cycles (OUT_REG=1).
- Reset mid-operation:
  - Assert Rst at clear count 100 -> restart at 0; Busy high a further 512 edges.
  - Assert Rst with 2 reads in flight -> RValid=0 and RD=0 immediately; no strobes after release.
- Generic build: ADDR_W=4, DATA_W=32, WEN_W=4, CLEAR_ON_RESET=0.
  - Busy=0 the first edge after reset.
  - Write 0xDEADBEEF to 0xF, read 0xF -> 0xDEADBEEF.
  - Write with WEN=4'b0100, WD=0x00770000 -> read returns 0xDE77BEEF.
